// File: rtl/serial_sub_pkg.sv
// rtl/serial_sub_pkg.sv - shared types and sizing helpers for the bit-serial subtractor
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 16;

    // Bit counter never needs to hold WIDTH itself, only 0..WIDTH-1.
    function automatic int cnt_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/full_adder.sv
// rtl/full_adder.sv - single-bit full adder cell
module full_adder (
    input  logic x,
    input  logic y,
    input  logic carry_in,
    output logic result,
    output logic carry_out
);

    assign result    = x ^ y ^ carry_in;
    assign carry_out = (x & y) | (x & carry_in) | (y & carry_in);

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - LSB-first bit-serial subtractor, out = in1 - in2, one bit per clock
// Optional signed-overflow output ovf when SERIAL_SUB_SIGNED_OVF_EN is defined.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    output logic             ovf,
`endif
    output logic             borrow
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic [CW-1:0]    r_cnt;
    logic             r_carry;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_out;
    logic             r_borrow;

    logic             w_b_inv;
    logic             w_sum;
    logic             w_cout;
    logic [WIDTH-1:0] w_res_next;

    // Subtraction as a + ~b + 1: invert the subtrahend bit, carry starts at 1.
    assign w_b_inv    = ~r_b[0];
    assign w_res_next = {w_sum, r_res[WIDTH-1:1]};

    full_adder u_fa (
        .x         (r_a[0]),
        .y         (w_b_inv),
        .carry_in  (r_carry),
        .result    (w_sum),
        .carry_out (w_cout)
    );

`ifdef SERIAL_SUB_SIGNED_OVF_EN
    logic r_a_msb;
    logic r_b_msb;
    logic r_ovf;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            if ((r_state == IDLE || r_state == FIN) && start) begin
                r_a_msb <= in1[WIDTH-1];
                r_b_msb <= in2[WIDTH-1];
            end
            if (r_state == RUN && r_cnt == LAST_CNT) begin
                r_ovf <= (r_a_msb != r_b_msb) && (w_sum != r_a_msb);
            end
        end
    end

    assign ovf = r_ovf;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_res    <= '0;
            r_cnt    <= '0;
            r_carry  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_out    <= '0;
            r_borrow <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE, FIN: begin
                    if (start) begin
                        r_a     <= in1;
                        r_b     <= in2;
                        r_res   <= '0;
                        r_cnt   <= '0;
                        r_carry <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                RUN: begin
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    r_res   <= w_res_next;
                    r_carry <= w_cout;
                    if (r_cnt == LAST_CNT) begin
                        r_out    <= w_res_next;
                        r_borrow <= ~w_cout;
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= FIN;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign out    = r_out;
    assign borrow = r_borrow;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - directed vector bench for serial_subtractor (WIDTH=16)
module tb_serial_subtractor;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] in1;
    logic [W-1:0] in2;
    logic         busy;
    logic         done;
    logic [W-1:0] out;
    logic         borrow;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    logic         ovf;
`endif

    int total = 0;
    int bad   = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .in1    (in1),
        .in2    (in2),
        .busy   (busy),
        .done   (done),
        .out    (out),
`ifdef SERIAL_SUB_SIGNED_OVF_EN
        .ovf    (ovf),
`endif
        .borrow (borrow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] o;
        logic         br;
        logic         ov;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic run_check(input string nm, input logic [W-1:0] x, input logic [W-1:0] y,
                             input logic [W-1:0] eo, input logic eb, input logic eov);
        logic [W-1:0] prev;
        int n;
        int bcnt;
        bit held;
        prev = out;
        n    = 0;
        bcnt = 0;
        held = 1'b1;
        @(negedge clk);
        in1   = x;
        in2   = y;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (!done && n < 60) begin
            if (busy) bcnt++;
            if (out !== prev) held = 1'b0;
            @(posedge clk); #1;
            n++;
        end
        chk({nm, " latency"}, n, 16);
        chk({nm, " busy cycles"}, bcnt, 16);
        chk({nm, " out held during run"}, 32'(held), 1);
        chk({nm, " busy at done"}, 32'(busy), 0);
        chk({nm, " out"}, 32'(out), 32'(eo));
        chk({nm, " borrow"}, 32'(borrow), 32'(eb));
`ifdef SERIAL_SUB_SIGNED_OVF_EN
        chk({nm, " ovf"}, 32'(ovf), 32'(eov));
`else
        if (eov === 1'bx) $display("unexpected x in vector %s", nm);
`endif
        @(posedge clk); #1;
        chk({nm, " done one cycle"}, 32'(done), 0);
    endtask

    initial begin
        int n;
        bit seen;

        vecs[0] = '{16'd100,  16'd37,   16'd63,   1'b0, 1'b0};
        vecs[1] = '{16'd5,    16'd9,    16'hFFFC, 1'b1, 1'b0};
        vecs[2] = '{16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b0};
        vecs[3] = '{16'd0,    16'd1,    16'hFFFF, 1'b1, 1'b0};
        vecs[4] = '{16'd0,    16'd0,    16'h0000, 1'b0, 1'b0};
        vecs[5] = '{16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1};
        vecs[6] = '{16'h7FFF, 16'hFFFF, 16'h8000, 1'b1, 1'b1};
        vecs[7] = '{16'd3,    16'd5,    16'hFFFE, 1'b1, 1'b0};
        vecs[8] = '{16'hABCD, 16'h1234, 16'h9999, 1'b0, 1'b0};
        vecs[9] = '{16'h1234, 16'h1234, 16'h0000, 1'b0, 1'b0};

        rst   = 1'b1;
        start = 1'b0;
        in1   = '0;
        in2   = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", 32'(busy), 0);
        chk("reset done", 32'(done), 0);
        chk("reset out", 32'(out), 0);
        chk("reset borrow", 32'(borrow), 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            run_check($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].o, vecs[i].br, vecs[i].ov);
        end

        // start while busy must be ignored
        @(negedge clk);
        in1 = 16'd10; in2 = 16'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        in1 = 16'd50; in2 = 16'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(n);
        chk("ignore done seen", 32'(done), 1);
        chk("ignore out", 32'(out), 7);
        repeat (20) @(posedge clk);
        #1;
        chk("ignore out stays", 32'(out), 7);
        chk("ignore idle", 32'(busy), 0);

        // back-to-back: start held through FIN
        @(negedge clk);
        in1 = 16'd300; in2 = 16'd200; start = 1'b1;
        @(posedge clk); #1;
        in1 = 16'd1000; in2 = 16'd1;
        wait_done(n);
        chk("b2b first latency", n, 16);
        chk("b2b first out", 32'(out), 100);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
            if (n == 1) begin
                chk("b2b reaccept busy", 32'(busy), 1);
                start = 1'b0;
            end
        end while (!done && n < 60);
        chk("b2b spacing", n, 17);
        chk("b2b second out", 32'(out), 999);
        chk("b2b second borrow", 32'(borrow), 0);

        // reset in the middle of RUN
        @(negedge clk);
        in1 = 16'd40; in2 = 16'd4; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst busy", 32'(busy), 0);
        chk("midrst done", 32'(done), 0);
        chk("midrst out", 32'(out), 0);
        chk("midrst borrow", 32'(borrow), 0);
        @(negedge clk);
        rst  = 1'b0;
        seen = 1'b0;
        repeat (25) begin
            @(posedge clk); #1;
            if (done) seen = 1'b1;
        end
        chk("midrst no done", 32'(seen), 0);
        run_check("after rst", 16'd20, 16'd5, 16'd15, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Multi-cycle, bit-serial unsigned/two's-complement subtractor computing out = in1 - in2, one bit per clock, LSB first. It reuses the existing full_adder cell with in2 inverted and an initial carry of 1. It complements the combinational adder datapath in the Week 10 arithmetic set: it trades latency for a single adder cell. Control is start/busy/done, so a small controller or testbench can sequence operations.

Parameters:
WIDTH, 16, operand and result width in bits (>=2)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
start  input  1  request a subtraction; sampled only when busy=0
in1  input  WIDTH  minuend; sampled on the edge that accepts start
in2  input  WIDTH  subtrahend; sampled on the edge that accepts start
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse: out/borrow just updated
out  output  WIDTH  result in1-in2 mod 2^WIDTH; held until next completion
borrow  output  1  1 when in1 < in2 (unsigned); held with out

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, port rst.
- Reset (rst=1 at an edge, any state): state=IDLE, busy=0, done=0, out=0, borrow=0. All internal shift registers, counter and carry are cleared. An in-flight operation is discarded, with no done pulse.
- FSM states: IDLE, RUN, FIN.
- IDLE: busy=0. If start=1, latch a=in1, b=in2, carry=1, cnt=0, then go to RUN.
- RUN: busy=1. Each edge, the full_adder computes (a[0], ~b[0], carry) and produces s and cout.
  - s shifts into the MSB of the internal result register res (shift right).
  - a and b shift right; carry becomes cout; cnt increments.
  - On the edge where cnt==WIDTH-1 (the WIDTH-th processed bit): out<=final res, borrow<=~cout, done<=1, go to FIN.
- FIN: busy=0, done=1 for exactly this one cycle, then done returns to 0.
  - start=1 in FIN is accepted exactly as in IDLE, giving back-to-back operation; otherwise go to IDLE.
- Latency: done is high in the cycle after the WIDTH-th edge following the accepting edge. For WIDTH=16, that is 16 edges after start is accepted.
- Throughput: one result per WIDTH+1 cycles back-to-back.
- start while busy=1 is ignored. in1/in2 changes while busy are ignored.
- out/borrow do not change during RUN. They keep the previous result until the completing edge.
- Counter width is clog2(WIDTH). The counter does not wrap within an operation.
- Edge values:
  - 0-0 gives out=0, borrow=0.
  - x-x gives out=0, borrow=0.
  - 0-1 gives all-ones, borrow=1.

Optional Feature:
SERIAL_SUB_SIGNED_OVF_EN
- Defined: adds output port ovf (1 bit), registered alongside out.
  - ovf = (a_msb != b_msb) && (res_msb != a_msb), using the latched operand MSBs. This is signed two's-complement overflow.
  - ovf resets to 0 and holds until the next completion.
- Undefined: port ovf is absent and no extra registers are built.

Decomposition:
- Package serial_sub_pkg:
  - state enum {IDLE, RUN, FIN}
  - default WIDTH localparam
  - counter-width helper function
- Sub-module: the existing full_adder (x, y, carry_in, result, carry_out), instantiated once. No other sub-modules.

Test Plan:
- 100-37, WIDTH=16 -> out=63, borrow=0; done pulses exactly 16 edges after start is accepted, for 1 cycle; busy=1 for 16 cycles.
- 5-9 -> out=0xFFFC, borrow=1. Then 0xFFFF-0xFFFF -> out=0, borrow=0. Then 0-1 -> out=0xFFFF, borrow=1.
- start=1 with 10-3, then start=1 with 50-1 at cycle 5 while busy -> second request ignored; out=7, and out stays 7 afterwards.
- Back-to-back: start held high across FIN with new operands 1000-1 -> second done 17 cycles after first, out=999.
- rst asserted at cycle 8 of RUN -> next edge busy=0, done=0, out=0, borrow=0, no done pulse. A following 20-5 returns 15.
- With SERIAL_SUB_SIGNED_OVF_EN: 0x8000-0x0001 -> out=0x7FFF, ovf=1. 0x7FFF-0xFFFF -> out=0x8000, ovf=1. 3-5 -> out=0xFFFE, ovf=0.
